// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder.
// Optional signed-overflow flag V is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             V;
`endif

`ifdef SERIAL_ADD_OVF_EN
  // Requester side: issues operands, observes status and result.
  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout, V
  );

  // Adder side.
  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout, V
  );
`else
  // Requester side: issues operands, observes status and result.
  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  // Adder side.
  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
`endif

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH clocks, LSB first.
// Operands are captured on an accepted start, the carry loops through carry_q, and the
// packed result is published into a separate output register on the RUN -> DONE edge so
// Sum/Cout never show partial values.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output V.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  // Counter only needs to reach WIDTH-1, so clog2(WIDTH) bits never wrap.
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers, carry loop and bit counter.
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  // Holds sum bits 0..WIDTH-2; bit WIDTH-1 comes straight from the cell on the last cycle.
  logic [WIDTH-2:0] sum_sr_q;
  logic [WIDTH-2:0] sum_sr_d;

  // Published result, stable outside the final RUN edge.
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             v_q;
`endif

  // Control strobes from the FSM.
  logic load;
  logic shift;
  logic last;

  // Single full-adder cell.
  logic fa_x;
  logic fa_y;
  logic fa_ci;
  logic fa_s;
  logic fa_co;

  assign fa_x  = a_sr_q[0];
  assign fa_y  = b_sr_q[0];
  assign fa_ci = carry_q;

  // Full-adder cell: sum and carry of the current bit position.
  always_comb begin
    fa_s  = fa_x ^ fa_y ^ fa_ci;
    fa_co = (fa_x & fa_y) | (fa_ci & (fa_x ^ fa_y));
  end

  // Sum register shifts right with the new bit entering at its MSB.
  always_comb begin
    sum_sr_d           = sum_sr_q >> 1;
    sum_sr_d[WIDTH-2]  = fa_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control strobes; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          load    = 1'b1;
        end
      end
      StRun: begin
        shift = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          last    = 1'b1;
        end
      end
      StDone: begin
        if (bus.start) begin
          state_d = StRun;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Serial datapath: capture on accept, then one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sr_q <= '0;
    end else if (load) begin
      a_sr_q   <= bus.A;
      b_sr_q   <= bus.B;
      carry_q  <= bus.Cin;
      cnt_q    <= '0;
      sum_sr_q <= '0;
    end else if (shift) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      carry_q  <= fa_co;
      sum_sr_q <= sum_sr_d;
      // Hold the counter at WIDTH-1 on the final bit so it never wraps.
      if (!last) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Result register: loaded only on the final RUN edge, so prior result holds during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      v_q    <= 1'b0;
`endif
    end else if (last) begin
      sum_q  <= {fa_s, sum_sr_q};
      cout_q <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
      // carry_q is the carry into the MSB during the last RUN cycle.
      v_q    <= carry_q ^ fa_co;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes hand-computed results into a
// queue, a negedge monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
    int           acc;   // clock edge on which start is accepted
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         hold_ok   = 1'b1;

  // Edge counter: after posedge number e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: result, latency, busy length and hold-during-RUN on each done.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        busy_cnt++;
        if (bus.Sum !== last_sum || bus.Cout !== last_cout) hold_ok = 1'b0;
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("done_expected", 64'(q.size()), 64'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", 64'(bus.Sum), 64'(e.sum));
          chk("cout", 64'(bus.Cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("v", 64'(bus.V), 64'(e.v));
`endif
          // done seen after edge cyc is sampled at edge cyc+1
          chk("latency", 64'(cyc + 1 - e.acc), 64'(W + 1));
          chk("busy_cycles", 64'(busy_cnt), 64'(W));
          chk("busy_with_done", 64'(bus.busy), 64'd0);
          chk("hold_during_run", 64'(hold_ok), 64'd1);
          last_sum  = e.sum;
          last_cout = e.cout;
        end
        hold_ok  = 1'b1;
        busy_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] es, input logic ec, input logic ev);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = ci;
    e = '{sum: es, cout: ec, v: ev, acc: cyc + 1};
    q.push_back(e);
    @(negedge clk);
    // Scramble operands after accept; only captured copies may matter.
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Cin   = ~ci;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * W && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'd0);
    q.delete();
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ndone;
    int   a0;
    exp_t e;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.Sum), 64'd0);
    chk("rst_cout", 64'(bus.Cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_v", 64'(bus.V), 64'd0);
`endif
    // Reset wins over start.
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    rst = 1'b0;

    // Full carry chain.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    drain();

    // Mixed pattern; previous result must hold during RUN.
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
    drain();

    // Start during RUN cycle 10 is ignored.
    issue(32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'h1;
    bus.B     = 32'h1;
    bus.Cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    ndone = done_cnt;
    repeat (2 * W) @(negedge clk);
    chk("no_queued_start", 64'(done_cnt), 64'(ndone));

    // Start held: 1+1 then 2+3 back to back, second accepted in DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'h1;
    bus.B     = 32'h1;
    bus.Cin   = 1'b0;
    a0 = cyc + 1;
    e = '{sum: 32'h2, cout: 1'b0, v: 1'b0, acc: a0};
    q.push_back(e);
    e = '{sum: 32'h5, cout: 1'b0, v: 1'b0, acc: a0 + W + 1};
    q.push_back(e);
    @(negedge clk);
    bus.A = 32'h2;
    bus.B = 32'h3;
    for (int i = 0; i < 4 * W && !bus.done; i++) @(negedge clk);
    chk("held_first_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    chk("no_idle_bubble", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    drain();

    // Reset at RUN cycle 15 discards the operation.
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_busy", 64'(bus.busy), 64'd0);
    chk("midrun_rst_done", 64'(bus.done), 64'd0);
    chk("midrun_rst_sum", 64'(bus.Sum), 64'd0);
    chk("midrun_rst_cout", 64'(bus.Cout), 64'd0);
    q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    hold_ok   = 1'b1;
    busy_cnt  = 0;
    ndone     = done_cnt;
    rst       = 1'b0;
    repeat (2 * W) @(negedge clk);
    chk("midrun_rst_no_done", 64'(done_cnt), 64'(ndone));
    issue(32'h5, 32'h7, 1'b0, 32'hC, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_ADD_OVF_EN
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer that time-shares one structural `full_adder` cell across a WIDTH-bit addition, one bit per clock, LSB first. It captures operands on a start request, runs the carry loop through a carry flip-flop, and presents the packed sum with a one-cycle done pulse. It is the area-minimal alternative to the ripple-carry adder for non-latency-critical paths.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  operand X; captured when start is accepted.
- B  in  WIDTH  operand Y; captured when start is accepted.
- Cin  in  1  carry-in; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; Sum and Cout are valid from this cycle on.
- Sum  out  WIDTH  result; held stable until the next accepted start.
- Cout  out  1  final carry; held like Sum.
- V  out  1  signed overflow; present only with SERIAL_ADD_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the bit counter reaches WIDTH-1.
  - DONE -> RUN on start; otherwise DONE -> IDLE.
- Accept: a start seen in IDLE or DONE loads the A and B shift registers, loads the carry FF with Cin and clears the bit counter. A start seen in RUN is ignored; it is not queued.
- RUN cycle k (k = 0..WIDTH-1):
  - The single full_adder instance sees X = A_sr[0], Y = B_sr[0], Ci = carry FF.
  - The S output shifts into the MSB of the sum shift register.
  - The Co output loads the carry FF.
  - A_sr and B_sr shift right by 1.
  - The counter increments.
- After WIDTH shifts, the sum register holds A+B+Cin mod 2^WIDTH and the carry FF holds the carry out of bit WIDTH-1.
- Sum and Cout:
  - They are driven from the sum register and carry FF.
  - They update only at the end of RUN, so they never show partial values outside RUN.
  - During RUN they hold the previous result. A separate output register, loaded on the RUN -> DONE edge, is acceptable.
- Counter width is clog2(WIDTH). It must not wrap within an operation.
- Arithmetic is unsigned modular. The result is bit-exact with an equivalent WIDTH-bit ripple-carry adder.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, Sum = 0, Cout = 0, V = 0. The counter, shift registers and carry FF are cleared.
- Start accepted at edge 0:
  - busy is high for edges 1..WIDTH.
  - done is high for exactly one cycle, after edge WIDTH+1.
- Latency from accepted start to done is WIDTH+1 clocks.
- Throughput with start held or re-asserted in DONE: one result per WIDTH+1 clocks, with no IDLE bubble.
- busy and done are never high in the same cycle.
- Reset mid-RUN: the next edge returns to IDLE with all outputs at reset values. The in-flight operation is discarded and done is not asserted.
- rst and start both high: reset wins.
- Operands may change freely after the accept edge. Only the captured copies are used.

## Configuration
- SERIAL_ADD_OVF_EN:
  - Defined:
    - Adds port V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - The carry into the MSB is registered during RUN cycle WIDTH-1.
    - V is updated and held with Sum.
  - Undefined: port V and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=32, A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Sum=0x00000000, Cout=1, done exactly 33 clocks after the start edge, busy high for 32 cycles.
- A=0x12345678, B=0x9ABCDEF0, Cin=1 -> Sum=0xACF13569, Cout=0. Sum holds its previous value throughout RUN.
- Start pulsed again at RUN cycle 10 with A=B=0x1 -> ignored; the first result completes unchanged and the next done occurs only after a fresh start.
- Start held high continuously with operands 1+1, then 2+3 -> done pulses every 33 clocks, with Sum=0x2 then Sum=0x5 and no IDLE cycle between operations.
- rst asserted at RUN cycle 15 -> IDLE next edge, all outputs 0, no done; a following start of 5+7 gives Sum=0xC.
- With SERIAL_ADD_OVF_EN:
  - 0x7FFFFFFF+0x1 -> V=1, Cout=0.
  - 0x80000000+0x80000000 -> V=1, Cout=1, Sum=0.
  - 0xFFFFFFFF+0x1 -> V=0.
